// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FN_MUL    = 3'b000;
    localparam logic [2:0] FN_MULH   = 3'b001;
    localparam logic [2:0] FN_MULHSU = 3'b010;
    localparam logic [2:0] FN_MULHU  = 3'b011;
    localparam logic [2:0] FN_DIV    = 3'b100;
    localparam logic [2:0] FN_DIVU   = 3'b101;
    localparam logic [2:0] FN_REM    = 3'b110;
    localparam logic [2:0] FN_REMU   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, sign-corrected at the end, written back as a one-cycle strobe.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A_data,
    input  logic [XLEN-1:0] B_data,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            wreg,
    output logic [4:0]      W_addr,
    output logic [XLEN-1:0] Data
);
    import muldiv_unit_pkg::*;

    // Handshake: start is taken only on an edge where busy is low; while busy is
    // high it is ignored (not queued). wreg is the sole qualifier of W_addr/Data.
    state_t              state;
    logic [2:0]          op;
    logic                neg;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     opd;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     rem;

    logic                a_sgn, b_sgn, div_zero, div_ovf;
    logic [XLEN-1:0]     a_abs, b_abs, fast_res;

    always_comb begin
        a_sgn    = (funct3 == FN_MULH || funct3 == FN_MULHSU ||
                    funct3 == FN_DIV  || funct3 == FN_REM) && A_data[XLEN-1];
        b_sgn    = (funct3 == FN_MULH || funct3 == FN_DIV || funct3 == FN_REM) && B_data[XLEN-1];
        a_abs    = a_sgn ? -A_data : A_data;
        b_abs    = b_sgn ? -B_data : B_data;
        div_zero = funct3[2] && (B_data == '0);
        div_ovf  = (funct3 == FN_DIV || funct3 == FN_REM) &&
                   (A_data == INT_MIN) && (B_data == DIV0_QUOT);
        // funct3[1] separates remainder from quotient within the divide group
        if (div_zero) fast_res = funct3[1] ? A_data : DIV0_QUOT;
        else          fast_res = funct3[1] ? '0 : INT_MIN;
    end

    logic [XLEN:0]       mul_sum, div_shift, div_trial;
    logic [XLEN-1:0]     rem_next, q_next, quot, remd, result;
    logic [2*XLEN-1:0]   acc_next, prod;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        div_shift = {rem, acc[XLEN-1]};
        div_trial = div_shift - {1'b0, opd};
        if (div_trial[XLEN]) begin
            rem_next = div_shift[XLEN-1:0];
            q_next   = {acc[XLEN-2:0], 1'b0};
        end else begin
            rem_next = div_trial[XLEN-1:0];
            q_next   = {acc[XLEN-2:0], 1'b1};
        end
        // Divide keeps the quotient (dividend shifting out) in the low word of acc
        acc_next = op[2] ? {{XLEN{1'b0}}, q_next} : {mul_sum, acc[XLEN-1:1]};
        prod     = neg ? -acc_next : acc_next;
        quot     = neg ? -q_next : q_next;
        remd     = neg ? -rem_next : rem_next;
        case (op)
            FN_MUL:                       result = prod[XLEN-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU: result = prod[2*XLEN-1:XLEN];
            FN_DIV, FN_DIVU:              result = quot;
            default:                      result = remd;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            wreg   <= 1'b0;
            W_addr <= '0;
            Data   <= '0;
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            opd    <= '0;
            acc    <= '0;
            rem    <= '0;
        end else begin
            wreg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        W_addr <= rd_addr;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        rem    <= '0;
                        neg    <= (funct3 == FN_REM) ? a_sgn : (a_sgn ^ b_sgn);
                        if (funct3[2]) begin
                            opd <= b_abs;
                            acc <= {{XLEN{1'b0}}, a_abs};
                        end else begin
                            opd <= a_abs;
                            acc <= {{XLEN{1'b0}}, b_abs};
                        end
                        if (div_zero || div_ovf) begin
                            Data  <= fast_res;
                            wreg  <= (rd_addr != '0);
                            state <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        Data  <= result;
                        wreg  <= (W_addr != '0);
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written corner
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] A_data;
  logic [31:0] B_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        wreg;
  logic [4:0]  W_addr;
  logic [31:0] Data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .funct3(funct3),
    .A_data(A_data), .B_data(B_data), .rd_addr(rd_addr),
    .busy(busy), .wreg(wreg), .W_addr(W_addr), .Data(Data)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model: plain 64-bit arithmetic on the RISC-V M definitions
  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    r  = '0;
    case (fn)
      FN_MUL:    r = up[31:0];
      FN_MULH:   begin sp = sa * sb; r = sp[63:32]; end
      FN_MULHSU: begin sp = sa * longint'({32'b0, b}); r = sp[63:32]; end
      FN_MULHU:  r = up[63:32];
      FN_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      FN_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      FN_REM:    r = (b == 0) ? a : 32'(sa % sb);
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    fast = fn[2] && ((b == 0) || (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return fast ? 1 : 33;
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // driver: called on a negedge; returns observations of one operation
  task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int inject_at,
                       output logic [31:0] data, output logic [4:0] waddr,
                       output int lat, output int pulses, output int bcyc);
    int cyc;
    funct3 = fn; A_data = a; B_data = b; rd_addr = rd; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    A_data = $urandom;
    B_data = $urandom;
    data = '0; waddr = '0; lat = 0; pulses = 0; bcyc = 0; cyc = 1;
    while (busy && cyc <= 40) begin
      bcyc++;
      if (wreg) begin
        pulses++;
        lat   = cyc;
        data  = Data;
        waddr = W_addr;
      end
      if (cyc == inject_at) begin
        start = 1'b1; funct3 = FN_MULHU; A_data = $urandom; B_data = $urandom; rd_addr = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
  endtask

  // scoreboard: expected data queued before the op, popped when the write is seen
  task automatic run_and_check(input string tag, input logic [2:0] fn, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input int inject_at,
                               input logic [31:0] exp_data, input int exp_lat);
    logic [31:0] data, expv;
    logic [4:0]  waddr;
    int lat, pulses, bcyc;
    exp_q.push_back(exp_data);
    do_op(fn, a, b, rd, inject_at, data, waddr, lat, pulses, bcyc);
    expv = exp_q.pop_front();
    check({tag, "_busy_cycles"}, bcyc, exp_lat);
    check({tag, "_idle_wreg"}, wreg, 1'b0);
    if (rd != 5'd0) begin
      check({tag, "_pulses"}, pulses, 1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_waddr"}, waddr, rd);
      check({tag, "_data"}, data, expv);
    end else begin
      check({tag, "_pulses_rd0"}, pulses, 0);
    end
  endtask

  initial begin
    logic [2:0]  fn;
    logic [31:0] a, b;
    logic [4:0]  rd;

    vecs[0]  = '{FN_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         33};
    vecs[1]  = '{FN_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE,  33};
    vecs[2]  = '{FN_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0000,  33};
    vecs[3]  = '{FN_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  33};
    vecs[4]  = '{FN_DIV,    32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33};
    vecs[5]  = '{FN_REM,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33};
    vecs[6]  = '{FN_DIVU,   32'd100,        32'd7,          5'd7,  32'd14,         33};
    vecs[7]  = '{FN_REMU,   32'd100,        32'd7,          5'd8,  32'd2,          33};
    vecs[8]  = '{FN_DIVU,   32'h1234,       32'd0,          5'd10, 32'hFFFF_FFFF,  1};
    vecs[9]  = '{FN_REM,    32'h1234,       32'd0,          5'd11, 32'h1234,       1};
    vecs[10] = '{FN_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1};
    vecs[11] = '{FN_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h0000_0000,  1};

    // reset held with start high: reset must win
    RESET = 1'b1; start = 1'b1; funct3 = FN_MUL; A_data = 32'd3; B_data = 32'd4; rd_addr = 5'd3;
    repeat (3) @(negedge CLK);
    check("reset_busy", busy, 1'b0);
    check("reset_wreg", wreg, 1'b0);
    check("reset_waddr", W_addr, 5'd0);
    check("reset_data", Data, 32'd0);
    RESET = 1'b0; start = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 12; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].rd, 0,
                    vecs[i].exp_data, vecs[i].exp_lat);

    // second start during MUL is ignored; only the first result is written
    run_and_check("ignore_start", FN_MUL, 32'd7, 32'd6, 5'd5, 10, 32'd42, 33);

    // rd=0: same busy timing, no write strobe
    run_and_check("rd_zero", FN_MUL, 32'd3, 32'd5, 5'd0, 0, 32'd15, 33);

    // reset in the middle of a DIV aborts without a write
    funct3 = FN_DIV; A_data = 32'hFFFF_0001; B_data = 32'd3; rd_addr = 5'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (19) @(negedge CLK);
    check("rst_mid_busy_before", busy, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_wreg", wreg, 1'b0);
    check("rst_mid_data", Data, 32'd0);
    run_and_check("post_reset", FN_DIVU, 32'd100, 32'd7, 5'd12, 0, 32'd14, 33);

    // randomized operations against the reference model
    for (int i = 0; i < 80; i++) begin
      fn = 3'($urandom_range(0, 7));
      a  = pick32();
      b  = pick32();
      rd = 5'($urandom_range(0, 31));
      run_and_check($sformatf("rnd%0d", i), fn, a, b, rd, 0, ref_model(fn, a, b), ref_latency(fn, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
